// File: rtl/rtc_bus_ctrl_pkg.sv
// Shared definitions for the RTC multiplexed-bus controller: state encoding,
// transfer direction constants and phase-counter width.
package rtc_pkg;

  localparam int PHASE_W = 8;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  // Encoding is sequential so a bus phase advances by incrementing the state.
  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_ADDR_SETUP  = 3'd1,
    ST_ADDR_STROBE = 3'd2,
    ST_ADDR_HOLD   = 3'd3,
    ST_DATA_SETUP  = 3'd4,
    ST_DATA_STROBE = 3'd5,
    ST_DATA_HOLD   = 3'd6,
    ST_DONE        = 3'd7
  } state_e;

endpackage

// File: rtl/rtc_bus_ctrl_if.sv
// Command handshake plus RTC pin bundle; master is the command/pad side,
// slave is the bus controller.
interface rtc_bus_ctrl_if;

  logic       start;
  logic       rw;
  logic [7:0] addr;
  logic [7:0] wdata;
  logic       busy;
  logic       done;
  logic [7:0] rdata;
  logic       cs_n;
  logic       rd_n;
  logic       wr_n;
  logic       ad_n;
  logic [7:0] ad_out;
  logic       ad_oe;
  logic [7:0] ad_in;

  modport master (
    output start, rw, addr, wdata, ad_in,
    input  busy, done, rdata, cs_n, rd_n, wr_n, ad_n, ad_out, ad_oe
  );

  modport slave (
    input  start, rw, addr, wdata, ad_in,
    output busy, done, rdata, cs_n, rd_n, wr_n, ad_n, ad_out, ad_oe
  );

endinterface

// File: rtl/rtc_bus_ctrl_reg8.sv
// 8-bit clocked holding register with load enable and asynchronous clear.
module rtc_bus_ctrl_reg8 (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] d,
  output logic [7:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) q <= 8'h00;
    else if (en) q <= d;
  end

endmodule

// File: rtl/rtc_bus_ctrl.sv
// Sequences one read or write on the RTC multiplexed address/data bus:
// address setup/strobe/hold, then data setup/strobe/hold, then a done pulse.
module rtc_bus_ctrl
  import rtc_pkg::*;
#(
  parameter int unsigned T_PHASE = 4
) (
  input logic           clk,
  input logic           reset,
  rtc_bus_ctrl_if.slave bus
);

  localparam logic [2:0] IDLE        = ST_IDLE;
  localparam logic [2:0] ADDR_SETUP  = ST_ADDR_SETUP;
  localparam logic [2:0] ADDR_STROBE = ST_ADDR_STROBE;
  localparam logic [2:0] ADDR_HOLD   = ST_ADDR_HOLD;
  localparam logic [2:0] DATA_SETUP  = ST_DATA_SETUP;
  localparam logic [2:0] DATA_STROBE = ST_DATA_STROBE;
  localparam logic [2:0] DATA_HOLD   = ST_DATA_HOLD;
  localparam logic [2:0] DONE        = ST_DONE;

  localparam logic [PHASE_W-1:0] LAST = PHASE_W'(T_PHASE - 1);

  logic [2:0]         state, next_state;
  logic [PHASE_W-1:0] cnt, next_cnt;
  logic               counting, phase_end;
  logic               rw_q;
  logic [7:0]         wdata_q;
  logic               cap_en;

  assign counting  = (state != IDLE) && (state != DONE);
  assign phase_end = counting && (cnt == LAST);

  always_comb begin
    next_state = state;
    next_cnt   = '0;
    if (counting && !phase_end) next_cnt = cnt + 1'b1;
    case (state)
      IDLE:    if (bus.start) next_state = ADDR_SETUP;
      DONE:    next_state = IDLE;
      default: if (phase_end) next_state = state + 3'd1;
    endcase
  end

  // Request fields are only needed after acceptance, so they carry no reset.
  always_ff @(posedge clk) begin
    if (state == IDLE && bus.start) begin
      rw_q    <= bus.rw;
      wdata_q <= bus.wdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      cap_en     <= 1'b0;
      bus.busy   <= 1'b0;
      bus.done   <= 1'b0;
      bus.cs_n   <= 1'b1;
      bus.rd_n   <= 1'b1;
      bus.wr_n   <= 1'b1;
      bus.ad_n   <= 1'b1;
      bus.ad_out <= 8'h00;
      bus.ad_oe  <= 1'b0;
    end else begin
      state    <= next_state;
      cnt      <= next_cnt;
      bus.done <= 1'b0;
      // High during the last DATA_STROBE cycle of a read; the holding
      // register loads ad_in on the edge that closes that cycle.
      cap_en   <= (rw_q == RW_READ) && (next_state == DATA_STROBE) && (next_cnt == LAST);
      case (state)
        IDLE: begin
          if (bus.start) begin
            bus.cs_n   <= 1'b0;
            bus.ad_n   <= 1'b0;
            bus.ad_oe  <= 1'b1;
            bus.ad_out <= bus.addr;
            bus.busy   <= 1'b1;
          end
        end
        ADDR_SETUP:  if (phase_end) bus.wr_n <= 1'b0;
        ADDR_STROBE: if (phase_end) bus.wr_n <= 1'b1;
        ADDR_HOLD: begin
          if (phase_end) begin
            bus.ad_n <= 1'b1;
            if (rw_q == RW_WRITE) begin
              bus.ad_out <= wdata_q;
              bus.ad_oe  <= 1'b1;
            end else begin
              bus.ad_oe  <= 1'b0;
            end
          end
        end
        DATA_SETUP: begin
          if (phase_end) begin
            if (rw_q == RW_WRITE) bus.wr_n <= 1'b0;
            else                  bus.rd_n <= 1'b0;
          end
        end
        DATA_STROBE: begin
          if (phase_end) begin
            bus.wr_n <= 1'b1;
            bus.rd_n <= 1'b1;
          end
        end
        DATA_HOLD: begin
          if (phase_end) begin
            bus.cs_n   <= 1'b1;
            bus.ad_oe  <= 1'b0;
            bus.done   <= 1'b1;
            bus.ad_n   <= 1'b1;
            bus.ad_out <= 8'h00;
          end
        end
        DONE:    bus.busy <= 1'b0;
        default: ;
      endcase
    end
  end

  rtc_bus_ctrl_reg8 u_rdata (
    .clk (clk),
    .rst (reset),
    .en  (cap_en),
    .d   (bus.ad_in),
    .q   (bus.rdata)
  );

endmodule

// File: tb/tb_rtc_bus_ctrl.sv
// Directed bench for rtc_bus_ctrl: one instance with T_PHASE=4 and one with
// T_PHASE=1, compared cycle by cycle against hand-derived bus waveforms.
module tb_rtc_bus_ctrl;

  logic clk;
  logic rst;
  int   checks;
  int   passed;

  rtc_bus_ctrl_if bus4();
  rtc_bus_ctrl_if bus1();

  rtc_bus_ctrl #(.T_PHASE(4)) dut4 (.clk(clk), .reset(rst), .bus(bus4));
  rtc_bus_ctrl #(.T_PHASE(1)) dut1 (.clk(clk), .reset(rst), .bus(bus1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {busy, done, cs_n, rd_n, wr_n, ad_n, ad_oe, ad_out, rdata}
  localparam logic [22:0] RST_VEC  = {1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00};
  localparam logic [22:0] FULL_MSK = 23'h7FFFFF;
  localparam logic [22:0] NOAD_MSK = 23'h7F00FF;

  function automatic logic [22:0] obs4();
    return {bus4.busy, bus4.done, bus4.cs_n, bus4.rd_n, bus4.wr_n, bus4.ad_n,
            bus4.ad_oe, bus4.ad_out, bus4.rdata};
  endfunction

  function automatic logic [22:0] obs1();
    return {bus1.busy, bus1.done, bus1.cs_n, bus1.rd_n, bus1.wr_n, bus1.ad_n,
            bus1.ad_oe, bus1.ad_out, bus1.rdata};
  endfunction

  // Expected T_PHASE=4 pins in cycle c (cycle c follows edge c-1, start taken at edge 0).
  function automatic logic [22:0] exp_t4(int c, bit rd, logic [7:0] a, logic [7:0] w,
                                         logic [7:0] old_r, logic [7:0] new_r);
    logic busy, done, cs_n, rd_n, wr_n, ad_n, ad_oe;
    logic [7:0] ad_out, rdata;
    busy   = (c <= 25);
    done   = (c == 25);
    cs_n   = !(c <= 24);
    rd_n   = !(rd && c >= 17 && c <= 20);
    wr_n   = !((c >= 5 && c <= 8) || (!rd && c >= 17 && c <= 20));
    ad_n   = !(c <= 12);
    ad_oe  = (c <= 12) || (!rd && c <= 24);
    ad_out = (c <= 12) ? a : ((c <= 24 && !rd) ? w : 8'h00);
    rdata  = (rd && c >= 21) ? new_r : old_r;
    return {busy, done, cs_n, rd_n, wr_n, ad_n, ad_oe, ad_out, rdata};
  endfunction

  function automatic logic [22:0] msk_t4(int c, bit rd);
    return (rd && c >= 13 && c <= 24) ? NOAD_MSK : FULL_MSK;
  endfunction

  task automatic monitor();
    forever begin
      @(negedge clk);
      checks++;
      if ((!bus4.rd_n && !bus4.wr_n) || (bus4.ad_oe && !bus4.rd_n) ||
          ((!bus4.rd_n || !bus4.wr_n) && bus4.cs_n) ||
          (!bus1.rd_n && !bus1.wr_n) || (bus1.ad_oe && !bus1.rd_n) ||
          ((!bus1.rd_n || !bus1.wr_n) && bus1.cs_n))
        $display("FAIL strobe_rules t=%0t got4 cs/rd/wr/oe=%b%b%b%b got1=%b%b%b%b required rd_n&wr_n not both low, no oe during rd, cs low in strobes",
                 $time, bus4.cs_n, bus4.rd_n, bus4.wr_n, bus4.ad_oe,
                 bus1.cs_n, bus1.rd_n, bus1.wr_n, bus1.ad_oe);
      else passed++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (obs4() !== RST_VEC) $display("FAIL reset_t4 got=%h required=%h", obs4(), RST_VEC);
    else passed++;
    checks++;
    if (obs1() !== RST_VEC) $display("FAIL reset_t1 got=%h required=%h", obs1(), RST_VEC);
    else passed++;
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (obs4() !== RST_VEC) $display("FAIL idle_t4 got=%h required=%h", obs4(), RST_VEC);
    else passed++;
    checks++;
    if (obs1() !== RST_VEC) $display("FAIL idle_t1 got=%h required=%h", obs1(), RST_VEC);
    else passed++;
  endtask

  task automatic test_write(logic [7:0] a, logic [7:0] w, logic [7:0] old_r);
    logic [22:0] e, o;
    @(posedge clk);
    #1 bus4.start = 1'b1; bus4.rw = 1'b0; bus4.addr = a; bus4.wdata = w; bus4.ad_in = 8'hC3;
    @(posedge clk);
    #1 bus4.start = 1'b0; bus4.rw = 1'b1; bus4.addr = ~a; bus4.wdata = ~w;
    for (int c = 1; c <= 26; c++) begin
      if (c > 1) begin @(posedge clk); #1; end
      @(negedge clk);
      e = exp_t4(c, 1'b0, a, w, old_r, old_r);
      o = obs4();
      checks++;
      if (o !== e) $display("FAIL write_%h c=%0d got=%h required=%h", a, c, o, e);
      else passed++;
    end
  endtask

  task automatic test_read(logic [7:0] a, logic [7:0] din, logic [7:0] old_r);
    logic [22:0] e, o, m;
    @(posedge clk);
    #1 bus4.start = 1'b1; bus4.rw = 1'b1; bus4.addr = a; bus4.wdata = 8'h5A; bus4.ad_in = 8'hC3;
    @(posedge clk);
    #1 bus4.start = 1'b0; bus4.rw = 1'b0; bus4.addr = ~a; bus4.wdata = 8'hA5;
    for (int c = 1; c <= 26; c++) begin
      if (c > 1) begin @(posedge clk); #1; end
      bus4.ad_in = (c >= 17 && c <= 20) ? din : 8'hC3;
      @(negedge clk);
      e = exp_t4(c, 1'b1, a, 8'h00, old_r, din);
      m = msk_t4(c, 1'b1);
      o = obs4();
      checks++;
      if ((o & m) !== (e & m)) $display("FAIL read_%h c=%0d got=%h required=%h", a, c, o & m, e & m);
      else passed++;
    end
  endtask

  task automatic test_ignore_start();
    logic [22:0] e, o;
    int dones, busys;
    dones = 0;
    busys = 0;
    @(posedge clk);
    #1 bus4.start = 1'b1; bus4.rw = 1'b0; bus4.addr = 8'h30; bus4.wdata = 8'h5A;
    @(posedge clk);
    #1 bus4.start = 1'b0;
    for (int c = 1; c <= 30; c++) begin
      if (c > 1) begin @(posedge clk); #1; end
      if (c == 6 || c == 25) bus4.start = 1'b1;
      if (c == 7 || c == 26) bus4.start = 1'b0;
      @(negedge clk);
      e = exp_t4(c, 1'b0, 8'h30, 8'h5A, 8'h37, 8'h37);
      o = obs4();
      if (bus4.done) dones++;
      if (bus4.busy) busys++;
      checks++;
      if (o !== e) $display("FAIL ignore_start c=%0d got=%h required=%h", c, o, e);
      else passed++;
    end
    checks++;
    if (dones !== 1) $display("FAIL ignore_done_count got=%0d required=1", dones);
    else passed++;
    checks++;
    if (busys !== 25) $display("FAIL ignore_busy_cycles got=%0d required=25", busys);
    else passed++;
  endtask

  task automatic test_reset_mid();
    logic [22:0] e, o;
    int dones;
    @(posedge clk);
    #1 bus4.start = 1'b1; bus4.rw = 1'b0; bus4.addr = 8'h44; bus4.wdata = 8'h99; bus4.ad_in = 8'hC3;
    @(posedge clk);
    #1 bus4.start = 1'b0;
    for (int c = 1; c <= 17; c++) begin
      if (c > 1) begin @(posedge clk); #1; end
      @(negedge clk);
      e = exp_t4(c, 1'b0, 8'h44, 8'h99, 8'h37, 8'h37);
      o = obs4();
      checks++;
      if (o !== e) $display("FAIL pre_reset c=%0d got=%h required=%h", c, o, e);
      else passed++;
    end
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (obs4() !== RST_VEC) $display("FAIL reset_mid_t4 got=%h required=%h", obs4(), RST_VEC);
    else passed++;
    checks++;
    if (obs1() !== RST_VEC) $display("FAIL reset_mid_t1 got=%h required=%h", obs1(), RST_VEC);
    else passed++;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    dones = 0;
    repeat (30) begin
      @(negedge clk);
      if (bus4.done) dones++;
    end
    checks++;
    if (dones !== 0) $display("FAIL reset_no_done got=%0d required=0", dones);
    else passed++;
  endtask

  task automatic test_back_to_back();
    logic [22:0] e, o, m;
    int k, p;
    logic [7:0] r;
    @(posedge clk);
    #1 bus1.start = 1'b1; bus1.rw = 1'b1; bus1.addr = 8'h66; bus1.wdata = 8'h00; bus1.ad_in = 8'h00;
    @(posedge clk);
    #1;
    for (int c = 1; c <= 30; c++) begin
      if (c > 1) begin @(posedge clk); #1; end
      bus1.ad_in = 8'(c);
      if (c == 24) bus1.start = 1'b0;
      @(negedge clk);
      m = FULL_MSK;
      if (c >= 25) begin
        e = {1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 8'd21};
      end else begin
        k = (c - 1) / 8;
        p = (c - 1) % 8 + 1;
        r = (p >= 6) ? 8'(5 + 8 * k) : ((k == 0) ? 8'h00 : 8'(5 + 8 * (k - 1)));
        case (p)
          1, 3:    e = {1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h66, r};
          2:       e = {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h66, r};
          4, 6:    e = {1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, r};
          5:       e = {1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, r};
          7:       e = {1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, r};
          default: e = {1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, r};
        endcase
        if (p >= 4 && p <= 6) m = NOAD_MSK;
      end
      o = obs1();
      checks++;
      if ((o & m) !== (e & m)) $display("FAIL back_to_back c=%0d got=%h required=%h", c, o & m, e & m);
      else passed++;
    end
  endtask

  initial begin
    checks = 0;
    passed = 0;
    rst = 1'b1;
    bus4.start = 1'b0; bus4.rw = 1'b0; bus4.addr = 8'h00; bus4.wdata = 8'h00; bus4.ad_in = 8'h00;
    bus1.start = 1'b0; bus1.rw = 1'b0; bus1.addr = 8'h00; bus1.wdata = 8'h00; bus1.ad_in = 8'h00;
    fork
      monitor();
    join_none
    test_reset();
    test_write(8'h21, 8'h45, 8'h00);
    test_read(8'h22, 8'h37, 8'h00);
    test_write(8'h10, 8'hAB, 8'h37);
    test_ignore_start();
    test_reset_mid();
    test_read(8'h55, 8'h6C, 8'h00);
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
